// File: rtl/wave_pkg.sv
// Shared definitions for the wave scheduler: FSM encoding and
// default speed, timing and LFSR constants.
package wave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAN  = 3'd1,
        SPAWN = 3'd2,
        FIGHT = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [23:0] BASE_SPEED   = 24'd400000;
    localparam logic [23:0] SPEED_STEP   = 24'd25000;
    localparam logic [23:0] MIN_SPEED    = 24'd100000;
    localparam logic [7:0]  SPAWN_GAP    = 8'd20;
    localparam logic [7:0]  BREAK_FRAMES = 8'd60;
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;

endpackage

// File: rtl/wave_scheduler_if.sv
// Lane-side bundle of the wave scheduler.
// master: scheduler (drives spawn/speed/status, reads lane_active).
// slave : lane array (reads spawn/speed/status, drives lane_active).
interface wave_scheduler_if #(
    parameter int N_LANES = 8
);
    logic [N_LANES-1:0] lane_active;
    logic [N_LANES-1:0] spawn_en;
    logic [23:0]        wave_speed;
    logic [7:0]         wave_num;
    logic               wave_clear;
    logic [2:0]         state;

    modport master (
        input  lane_active,
        output spawn_en, wave_speed, wave_num, wave_clear, state
    );

    modport slave (
        output lane_active,
        input  spawn_en, wave_speed, wave_num, wave_clear, state
    );
endinterface

// File: rtl/wave_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) with load and advance.
// Ports: clk, rst_n, load (reseed), adv (step once), value.
module wave_lfsr
    import wave_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (adv) begin
            value <= {value[6:0],
                      value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/wave_scheduler.sv
// Central wave sequencer: plans lane masks, staggers spawns,
// detects wave clear, runs the intermission and sets wave_speed.
// Ports: clk, rst_n, frame_tick, game_start_on, game_over_on,
// pause, bus (lane_active in; spawn_en, wave_speed, wave_num,
// wave_clear, state out).
module wave_scheduler
    import wave_pkg::*;
#(
    parameter int          N_LANES      = 8,
    parameter logic [23:0] BASE_SPEED   = wave_pkg::BASE_SPEED,
    parameter logic [23:0] SPEED_STEP   = wave_pkg::SPEED_STEP,
    parameter logic [23:0] MIN_SPEED    = wave_pkg::MIN_SPEED,
    parameter logic [7:0]  SPAWN_GAP    = wave_pkg::SPAWN_GAP,
    parameter logic [7:0]  BREAK_FRAMES = wave_pkg::BREAK_FRAMES,
    parameter logic [7:0]  LFSR_SEED    = wave_pkg::LFSR_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic game_start_on,
    input  logic game_over_on,
    input  logic pause,
    wave_scheduler_if.master bus
);

    state_t             st;
    logic [N_LANES-1:0] pending;
    logic [N_LANES-1:0] tgt;
    logic [N_LANES-1:0] spawn_r;
    logic [N_LANES-1:0] plan_mask;
    logic [7:0]         gap_cnt;
    logic [7:0]         brk_cnt;
    logic [7:0]         wave_r;
    logic [7:0]         wn_next;
    logic [23:0]        speed_r;
    logic [23:0]        speed_next;
    logic               first;
    logic               settle;
    logic               clear_r;
    logic               stall;
    logic               due;
    logic               lfsr_load;
    logic               lfsr_adv;
    logic [7:0]         lfsr_q;
    logic [31:0]        dec;
    logic signed [31:0] spd;

    wave_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .adv   (lfsr_adv),
        .value (lfsr_q)
    );

    assign lfsr_load = (st == IDLE) && game_start_on && !pause;
    assign lfsr_adv  = (st == PLAN) && !game_over_on && !pause;

    // Lowest set bit of pending, one-hot.
    assign tgt   = pending & (~pending + N_LANES'(1));
    assign stall = |(bus.lane_active & tgt);
    // First spawn of a wave fires on the first tick; gap_cnt
    // parks at SPAWN_GAP-1 while a busy lane stalls the spawn.
    assign due   = first || (gap_cnt == SPAWN_GAP - 8'd1);

    assign plan_mask = (lfsr_q[N_LANES-1:0] == '0)
                     ? N_LANES'(1) : lfsr_q[N_LANES-1:0];

    always_comb begin
        wn_next    = (wave_r == 8'hFF) ? wave_r : wave_r + 8'd1;
        dec        = (32'(wn_next) - 32'd1) * 32'(SPEED_STEP);
        spd        = signed'(32'(BASE_SPEED) - dec);
        speed_next = spd[23:0];
        if (spd < signed'(32'(MIN_SPEED))) begin
            speed_next = MIN_SPEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            pending <= '0;
            gap_cnt <= '0;
            brk_cnt <= '0;
            first   <= 1'b0;
            settle  <= 1'b0;
            spawn_r <= '0;
            clear_r <= 1'b0;
            wave_r  <= '0;
            speed_r <= BASE_SPEED;
        end else begin
            spawn_r <= '0;
            clear_r <= 1'b0;
            if (st != IDLE && game_over_on) begin
                st      <= IDLE;
                pending <= '0;
            end else if (!pause) begin
                unique case (st)
                    IDLE: begin
                        if (game_start_on) begin
                            wave_r <= '0;
                        end else if (!game_over_on) begin
                            st <= PLAN;
                        end
                    end
                    PLAN: begin
                        wave_r  <= wn_next;
                        pending <= plan_mask;
                        speed_r <= speed_next;
                        gap_cnt <= '0;
                        first   <= 1'b1;
                        st      <= SPAWN;
                    end
                    SPAWN: begin
                        if (frame_tick) begin
                            if (!due) begin
                                gap_cnt <= gap_cnt + 8'd1;
                            end else if (!stall) begin
                                spawn_r <= tgt;
                                pending <= pending & ~tgt;
                                gap_cnt <= '0;
                                first   <= 1'b0;
                                if ((pending & ~tgt) == '0) begin
                                    st     <= FIGHT;
                                    settle <= 1'b1;
                                end
                            end
                        end
                    end
                    FIGHT: begin
                        if (frame_tick) begin
                            if (settle) begin
                                settle <= 1'b0;
                            end else if (bus.lane_active == '0) begin
                                clear_r <= 1'b1;
                                brk_cnt <= '0;
                                st      <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (frame_tick) begin
                            if (brk_cnt == BREAK_FRAMES - 8'd1) begin
                                st <= PLAN;
                            end else begin
                                brk_cnt <= brk_cnt + 8'd1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign bus.spawn_en   = spawn_r;
    assign bus.wave_speed = speed_r;
    assign bus.wave_num   = wave_r;
    assign bus.wave_clear = clear_r;
    assign bus.state      = st;

endmodule

// File: tb/tb_wave_scheduler.sv
// Scoreboard bench for wave_scheduler: stimulus queues expected
// spawn/clear events, a negedge monitor pops and compares them.
module tb_wave_scheduler;
    import wave_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic game_start_on = 1'b1;
    logic game_over_on = 1'b0;
    logic pause = 1'b0;

    wave_scheduler_if #(.N_LANES(8)) bus ();

    wave_scheduler #(.N_LANES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .game_start_on (game_start_on),
        .game_over_on  (game_over_on),
        .pause         (pause),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_clear;
        logic [7:0] mask;
        int         tick;
        int         wn;
        int         spd;
    } ev_t;

    ev_t q[$];
    int  tick_no = 0;
    int  n_pass = 0;
    int  n_total = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_speed(input int wn);
        int s;
        s = 400000 - (wn - 1) * 25000;
        return (s < 100000) ? 100000 : s;
    endfunction

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // One frame_tick pulse; returns on the negedge after the
    // sampling edge, so registered responses are visible.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        tick_no++;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.spawn_en != '0 || bus.wave_clear)) begin
            if (q.size() == 0) begin
                chk("unexpected_event",
                    {bus.wave_clear, bus.spawn_en}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("event_kind", bus.wave_clear, e.is_clear);
                chk("spawn_mask", bus.spawn_en, e.mask);
                chk("event_tick", tick_no, e.tick);
                chk("event_wave", bus.wave_num, e.wn);
                chk("event_speed", bus.wave_speed, e.spd);
            end
        end
    end

    task automatic push_ev(input bit clr, input logic [7:0] m,
                           input int wn);
        ev_t e;
        e.is_clear = clr;
        e.mask     = m;
        e.tick     = tick_no + 1;
        e.wn       = wn;
        e.spd      = exp_speed(wn);
        q.push_back(e);
    endtask

    // Entered with the DUT in SPAWN; leaves it in SPAWN of the
    // next wave unless stop_fight is set.
    task automatic run_wave(input logic [7:0] mask, input int wn,
                            input bit with_active, input bit do_pause,
                            input int stall_lane, input bit stop_fight);
        int k;
        k = 0;
        chk("wave_num", bus.wave_num, wn);
        chk("wave_speed", bus.wave_speed, exp_speed(wn));
        chk("state_spawn", bus.state, 2);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                if (k > 0) begin
                    if (do_pause && k == 1) begin
                        repeat (5) do_tick();
                        pause = 1'b1;
                        repeat (100) do_tick();
                        chk("pause_state", bus.state, 2);
                        pause = 1'b0;
                        repeat (14) do_tick();
                    end else begin
                        repeat (19) do_tick();
                    end
                end
                if (i == stall_lane) begin
                    bus.lane_active[i] = 1'b1;
                    repeat (5) do_tick();
                    chk("stall_state", bus.state, 2);
                    bus.lane_active[i] = 1'b0;
                end
                push_ev(1'b0, 8'(1 << i), wn);
                do_tick();
                k++;
            end
        end
        chk("state_fight", bus.state, 3);
        if (stop_fight) return;
        if (with_active) begin
            bus.lane_active = '1;
            do_tick();
            do_tick();
            chk("fight_busy", bus.state, 3);
            bus.lane_active = '0;
        end else begin
            do_tick();
        end
        push_ev(1'b1, 8'h00, wn);
        do_tick();
        chk("state_break", bus.state, 4);
        repeat (59) do_tick();
        chk("break_hold", bus.state, 4);
        do_tick();
        chk("state_plan", bus.state, 1);
        @(negedge clk);
    endtask

    logic [7:0] hand [5] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54};
    logic [7:0] l;

    initial begin
        bus.lane_active = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_speed", bus.wave_speed, 400000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", bus.state, 0);
        chk("idle_wave", bus.wave_num, 0);
        chk("idle_spawn", bus.spawn_en, 0);
        game_start_on = 1'b0;
        @(negedge clk);
        chk("plan_state", bus.state, 1);
        @(negedge clk);

        run_wave(hand[0], 1, 1'b1, 1'b0, -1, 1'b0);
        run_wave(hand[1], 2, 1'b0, 1'b1, -1, 1'b0);
        run_wave(hand[2], 3, 1'b0, 1'b0, 2, 1'b0);
        run_wave(hand[3], 4, 1'b0, 1'b0, -1, 1'b0);
        chk("speed_w5", bus.wave_speed, 300000);
        run_wave(hand[4], 5, 1'b0, 1'b0, -1, 1'b0);
        l = hand[4];
        for (int wn = 6; wn <= 13; wn++) begin
            l = lfsr_nxt(l);
            run_wave((l == 8'h00) ? 8'h01 : l, wn,
                     1'b0, 1'b0, -1, 1'b0);
        end

        chk("w14_num", bus.wave_num, 14);
        chk("w14_speed", bus.wave_speed, 100000);
        chk("w14_state", bus.state, 2);
        @(negedge clk);
        frame_tick = 1'b1;
        game_over_on = 1'b1;
        tick_no++;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("gover_state", bus.state, 0);
        chk("gover_wave", bus.wave_num, 14);
        chk("gover_speed", bus.wave_speed, 100000);
        repeat (3) @(negedge clk);
        chk("gover_hold", bus.state, 0);
        game_over_on = 1'b0;
        game_start_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("restart_wave0", bus.wave_num, 0);
        game_start_on = 1'b0;
        @(negedge clk);
        chk("restart_plan", bus.state, 1);
        @(negedge clk);
        run_wave(8'hA5, 1, 1'b0, 1'b0, -1, 1'b1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_wave", bus.wave_num, 0);
        chk("arst_speed", bus.wave_speed, 400000);
        chk("arst_spawn", bus.spawn_en, 0);
        chk("arst_clear", bus.wave_clear, 0);
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
